// File: rtl/ahb_modport_mem_slave.sv
// AHB-Lite slave backed by a word-organised SRAM: zero-wait OKAY, two-cycle ERROR.
// Optional build macro AHB_MEM_WPROT_EN: unprivileged writes (hprot[1]=0) take the ERROR path.
module ahb_modport_mem_slave #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hselx,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [3:0]        hprot,
  input  logic              hmastlock,
  input  logic              hready,
  input  logic [DATA_W-1:0] hwdata,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout,
  output logic              hresp
);

  localparam int          IDX_W      = $clog2(MEM_DEPTH);
  localparam logic [31:0] BYTE_LIMIT = 32'(4 * MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_e;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      2'd0:    lane_mask = 4'b0001 << lsb;
      2'd1:    lane_mask = lsb[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic [IDX_W+1:0]  addr_q, addr_d;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic        sample_s, accept_s, bad_s, misalign_s, range_s, prot_bad_s, we_s;
  logic [3:0]  be_s;
  logic [31:0] haddr_ext_s;
  logic        unused_s;

  assign unused_s    = ^{hburst, hmastlock, hprot};
  assign haddr_ext_s = 32'(haddr);

  // hready is low during the first error cycle, but gate on state too so a
  // misbehaving interconnect cannot overlap a new transfer with the error.
  assign sample_s   = hready & (state_q != ST_ERR1);
  assign accept_s   = sample_s & hselx & htrans[1];
  assign misalign_s = ((hsize == 3'd1) & haddr[0]) | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));
  assign range_s    = (haddr_ext_s >= BYTE_LIMIT);
`ifdef AHB_MEM_WPROT_EN
  assign prot_bad_s = hwrite & ~hprot[1];
`else
  assign prot_bad_s = 1'b0;
`endif
  assign bad_s = (hsize > 3'd2) | misalign_s | range_s | prot_bad_s;

  // Next-state: error sequencer plus address-phase capture.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    write_d = write_q;
    size_d  = size_q;
    addr_d  = addr_q;
    case (state_q)
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = ST_OK;
      ST_OK:   state_d = ST_OK;
      default: state_d = ST_OK;
    endcase
    if (sample_s) begin
      valid_d = 1'b0;
      if (accept_s && bad_s) begin
        state_d = ST_ERR1;
      end else if (accept_s) begin
        valid_d = 1'b1;
        write_d = hwrite;
        size_d  = hsize[1:0];
        addr_d  = haddr[IDX_W+1:0];
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // State and address-phase registers.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_OK;
      valid_q <= 1'b0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      write_q <= write_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
    end
  end

  assign be_s = lane_mask(size_q, addr_q[1:0]);
  assign we_s = valid_q & write_q & hready;

  // Storage is deliberately not reset; a write aborted by reset never commits
  // because valid_q clears asynchronously.
  always_ff @(posedge hclk) begin
    if (we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_q[addr_q[IDX_W+1:2]][8*i +: 8] <= hwdata[8*i +: 8];
        end
      end
    end
  end

  // Read data only inside a legal read data phase; zero otherwise.
  always_comb begin
    hrdata = {DATA_W{1'b0}};
    if (valid_q && !write_q) begin
      hrdata = mem_q[addr_q[IDX_W+1:2]];
    end else begin
      hrdata = {DATA_W{1'b0}};
    end
  end

  assign hreadyout = (state_q != ST_ERR1);
  assign hresp     = (state_q != ST_OK);

endmodule

// File: tb/tb_ahb_modport_mem_slave.sv
// Directed bench for ahb_modport_mem_slave with a byte-level reference model and per-cycle compare.
module tb_ahb_modport_mem_slave;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hselx;
  logic [15:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic        hready;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  assign hready = hreadyout;

  ahb_modport_mem_slave dut (
    .hclk(hclk), .hresetn(hresetn), .hselx(hselx), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock),
    .hready(hready), .hwdata(hwdata), .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte memory with known flags, queue of expected per-cycle responses.
  typedef struct { bit rdy; bit resp; bit rd; int waddr; } exp_t;
  exp_t     q[$];
  logic [7:0] mb [4096];
  bit         mk [4096];
  bit         pw_valid = 1'b0;
  int         pw_addr, pw_nbytes;

  function automatic logic [31:0] mdl_word(input int a);
    logic [31:0] w = 32'h0;
    for (int l = 0; l < 4; l++) if (mk[a + l]) w[8*l +: 8] = mb[a + l];
    return w;
  endfunction

  function automatic logic [31:0] mdl_mask(input int a);
    logic [31:0] m = 32'h0;
    for (int l = 0; l < 4; l++) if (mk[a + l]) m[8*l +: 8] = 8'hFF;
    return m;
  endfunction

  initial begin : model
    bit ok;
    int a, n;
    forever begin
      @(posedge hclk or negedge hresetn);
      if (!hresetn) begin
        q.delete();
        pw_valid = 1'b0;
      end else begin
        if (pw_valid && hready) begin
          for (int b = 0; b < pw_nbytes; b++) begin
            mb[pw_addr + b] = hwdata[8*((pw_addr + b) % 4) +: 8];
            mk[pw_addr + b] = 1'b1;
          end
          pw_valid = 1'b0;
        end
        if (hready && hselx && htrans[1]) begin
          a  = int'(haddr);
          ok = 1'b1;
          if (hsize > 3'd2) ok = 1'b0;
          else begin
            n = 1 << hsize;
            if (a % n != 0) ok = 1'b0;
          end
          if (a >= 4096) ok = 1'b0;
`ifdef AHB_MEM_WPROT_EN
          if (hwrite && !hprot[1]) ok = 1'b0;
`endif
          if (!ok) begin
            q.push_back('{1'b0, 1'b1, 1'b0, 0});
            q.push_back('{1'b1, 1'b1, 1'b0, 0});
          end else if (hwrite) begin
            pw_valid  = 1'b1;
            pw_addr   = a;
            pw_nbytes = n;
            q.push_back('{1'b1, 1'b0, 1'b0, 0});
          end else begin
            q.push_back('{1'b1, 1'b0, 1'b1, a - (a % 4)});
          end
        end
      end
    end
  end

  initial begin : cmp
    exp_t e;
    logic [31:0] em;
    forever begin
      @(negedge hclk);
      if (q.size() > 0) e = q.pop_front();
      else e = '{1'b1, 1'b0, 1'b0, 0};
      chk("cyc_hreadyout", {31'b0, hreadyout}, {31'b0, e.rdy});
      chk("cyc_hresp", {31'b0, hresp}, {31'b0, e.resp});
      if (e.rd) begin
        em = mdl_mask(e.waddr);
        if (em != 32'h0) chk("cyc_hrdata", hrdata & em, mdl_word(e.waddr) & em);
      end else begin
        chk("cyc_hrdata_zero", hrdata, 32'h0);
      end
    end
  end

  // Driver: one address phase per call; the data for a write goes out on the next call.
  logic [31:0] pend = 32'h0;

  task automatic beat(input bit sel, input logic [1:0] tr, input bit wr, input logic [2:0] sz,
                      input logic [15:0] a, input logic [31:0] wd, input logic [3:0] pr);
    hselx  = sel;  htrans = tr;  hwrite = wr;  hsize = sz;
    haddr  = a;    hprot  = pr;  hwdata = pend; pend = wd;
    hburst = (tr == 2'b11) ? 3'b011 : 3'b000;
    @(posedge hclk);
    @(negedge hclk);
  endtask

  task automatic wr(input logic [2:0] sz, input logic [15:0] a, input logic [31:0] d);
    beat(1'b1, 2'b10, 1'b1, sz, a, d, 4'b0011);
  endtask
  task automatic rd(input logic [15:0] a);
    beat(1'b1, 2'b10, 1'b0, 3'd2, a, 32'h0, 4'b0011);
  endtask
  task automatic idle();
    beat(1'b1, 2'b00, 1'b0, 3'd2, 16'h0, 32'h0, 4'b0011);
  endtask

  task automatic expect_err(input string nm);
    chk({nm, "_c1_ready"}, {31'b0, hreadyout}, 32'd0);
    chk({nm, "_c1_resp"}, {31'b0, hresp}, 32'd1);
    chk({nm, "_c1_rdata"}, hrdata, 32'h0);
    idle();
    chk({nm, "_c2_ready"}, {31'b0, hreadyout}, 32'd1);
    chk({nm, "_c2_resp"}, {31'b0, hresp}, 32'd1);
    idle();
    chk({nm, "_done_resp"}, {31'b0, hresp}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    hresetn = 1'b0; hselx = 1'b0; haddr = 16'h0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd2; hburst = 3'd0; hprot = 4'b0011; hmastlock = 1'b0; hwdata = 32'h0;
    repeat (3) @(negedge hclk);
    chk("rst_ready", {31'b0, hreadyout}, 32'd1);
    chk("rst_resp", {31'b0, hresp}, 32'd0);
    chk("rst_rdata", hrdata, 32'h0);
    hresetn = 1'b1;
    idle();

    // Back-to-back word write then read.
    wr(3'd2, 16'h0010, 32'hDEADBEEF);
    rd(16'h0010);
    chk("b2b_rdata", hrdata, 32'hDEADBEEF);
    chk("b2b_ready", {31'b0, hreadyout}, 32'd1);

    // Byte and halfword lanes, including a SEQ beat.
    wr(3'd2, 16'h0020, 32'h11223344);
    wr(3'd0, 16'h0023, 32'hAA000000);
    beat(1'b1, 2'b11, 1'b1, 3'd1, 16'h0020, 32'h0000BBCC, 4'b0011);
    rd(16'h0020);
    chk("lanes_rdata", hrdata, 32'hAA22BBCC);
    wr(3'd1, 16'h0022, 32'h55660000);
    wr(3'd0, 16'h0021, 32'h00007700);
    rd(16'h0020);
    chk("lanes2_rdata", hrdata, 32'h556677CC);

    // Error responses.
    rd(16'h0002);      expect_err("err_misalign_rd");
    rd(16'h1000);      expect_err("err_range_rd");
    wr(3'd1, 16'h0011, 32'hFFFFFFFF); expect_err("err_misalign_wr");
    wr(3'd3, 16'h0010, 32'hFFFFFFFF); expect_err("err_size_wr");
    wr(3'd2, 16'h1004, 32'hFFFFFFFF); expect_err("err_range_wr");
    rd(16'h0010);
    chk("err_mem_unchanged", hrdata, 32'hDEADBEEF);

    // IDLE, BUSY and deselected writes do nothing.
    beat(1'b1, 2'b00, 1'b1, 3'd2, 16'h0010, 32'h01010101, 4'b0011);
    chk("idle_ready", {31'b0, hreadyout}, 32'd1);
    beat(1'b1, 2'b01, 1'b1, 3'd2, 16'h0010, 32'h02020202, 4'b0011);
    chk("busy_resp", {31'b0, hresp}, 32'd0);
    beat(1'b0, 2'b10, 1'b1, 3'd2, 16'h0010, 32'h03030303, 4'b0011);
    chk("desel_ready", {31'b0, hreadyout}, 32'd1);
    rd(16'h0010);
    chk("noacc_mem", hrdata, 32'hDEADBEEF);

    // Reset during the data phase of a write aborts it.
    wr(3'd2, 16'h0030, 32'hCAFEF00D);
    idle();
    wr(3'd2, 16'h0030, 32'h12345678);
    hwdata = 32'h12345678; htrans = 2'b00; pend = 32'h0;
    hresetn = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, hreadyout}, 32'd1);
    chk("midrst_resp", {31'b0, hresp}, 32'd0);
    chk("midrst_rdata", hrdata, 32'h0);
    @(negedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    idle();
    rd(16'h0030);
    chk("midrst_not_committed", hrdata, 32'hCAFEF00D);

    // Write-protection behaviour depends on the build.
    wr(3'd2, 16'h0040, 32'h77777777);
    beat(1'b1, 2'b10, 1'b1, 3'd2, 16'h0040, 32'h01020304, 4'b0001);
`ifdef AHB_MEM_WPROT_EN
    expect_err("wprot_unpriv");
    rd(16'h0040);
    chk("wprot_unchanged", hrdata, 32'h77777777);
    beat(1'b1, 2'b10, 1'b1, 3'd2, 16'h0040, 32'h0A0B0C0D, 4'b0011);
    rd(16'h0040);
    chk("wprot_priv_stored", hrdata, 32'h0A0B0C0D);
`else
    chk("noprot_resp", {31'b0, hresp}, 32'd0);
    rd(16'h0040);
    chk("noprot_stored", hrdata, 32'h01020304);
`endif

    // Pin the model against hand-computed contents.
    chk("model_0x10", mdl_word(16), 32'hDEADBEEF);
    chk("model_0x20", mdl_word(32), 32'h556677CC);
    chk("model_0x30", mdl_word(48), 32'hCAFEF00D);

    idle();
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
